sobel_window_controller: RTL
============================

# sobel_window_controller

Sequences one Sobel evaluation at a time around the gradient datapath:
- collects a 3x3 pixel window from an upstream stream;
- drives the shared `windowBuffer` and `start_calculations` into the horizontal and vertical gradient blocks;
- waits for both done flags, combines `gx` and `gy` into a saturated 8-bit edge magnitude with a threshold flag;
- hands the result downstream over a valid/ready handshake.

It sits between the line-buffer/pixel source and the output pixel writer.

## Interface
- `THRESHOLD`, default 128: edge_flag set when the saturated magnitude is ≥ this value.
- `TIMEOUT`, default 16: maximum CALC cycles before aborting; valid range 1..255.
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous active-low reset.
- `pixel_in` in 8: window pixel, raster order within the window (index 0 = top-left, 8 = bottom-right).
- `pixel_valid` in 1: `pixel_in` is valid this cycle.
- `pixel_ready` out 1: controller accepts a pixel this cycle.
- `windowBuffer` out 8 x [0:8]: registered window driven to both gradient blocks.
- `start_calculations` out 1: request to gradient blocks.
- `h_done` in 1: horizontal gradient done.
- `v_done` in 1: vertical gradient done.
- `gx` in 11: horizontal gradient magnitude, unsigned.
- `gy` in 11: vertical gradient magnitude, unsigned.
- `edge_out` out 8: saturated magnitude.
- `edge_flag` out 1: `edge_out` ≥ THRESHOLD.
- `out_valid` out 1: `edge_out` and `edge_flag` are valid.
- `out_ready` in 1: downstream accepts the result.
- `calc_error` out 1: one-cycle pulse on timeout abort.
- `window_count` out 16: number of results accepted downstream, wraps at 65535→0.

## Operation
- States: IDLE, LOAD, CALC, OUTPUT.
- **Reset** (async, `n_rst`=0):
  - state = IDLE;
  - all outputs 0: `windowBuffer` entries, `edge_out`, `edge_flag`, `out_valid`, `start_calculations`, `calc_error`, `window_count`;
  - load index = 0, done latches = 0, timeout counter = 0.
- **Pixel acceptance:** `pixel_ready` = 1 in IDLE and LOAD, 0 otherwise. A pixel is accepted when `pixel_valid` && `pixel_ready`; it is written to `windowBuffer[idx]` and idx increments.
- **IDLE:** on an accepted pixel → LOAD with idx = 1.
- **LOAD:**
  - Cycles with `pixel_valid` = 0 stall with no change.
  - When idx = 8 is accepted → CALC; idx clears to 0; done latches and timeout counter clear.
- **CALC:**
  - `start_calculations` = 1, Moore output.
  - Each cycle: `h_seen |= h_done`, `v_seen |= v_done`. The two dones may arrive in different cycles.
  - When (`h_seen` | `h_done`) && (`v_seen` | `v_done`):
    - capture sum = gx + gy (12-bit, no overflow);
    - `edge_out` = (sum > 255) ? 255 : sum[7:0];
    - `edge_flag` = (`edge_out` ≥ THRESHOLD);
    - → OUTPUT.
  - gx/gy are sampled in the cycle the second done is seen.
  - Otherwise the timeout counter increments. On reaching TIMEOUT: `calc_error` pulses 1 cycle, → IDLE, no result emitted, `windowBuffer` retained.
- **OUTPUT:**
  - `out_valid` = 1; `edge_out`/`edge_flag` held stable until `out_ready`.
  - On `out_valid` && `out_ready`: `window_count` += 1, → IDLE.
- `windowBuffer` changes only on accepted pixels, so it is stable throughout CALC and OUTPUT.
- No new window is accepted while CALC or OUTPUT is pending (`pixel_ready` = 0).

## Timing
- All outputs are registered or Moore-decoded from registered state; no combinational input-to-output paths.
- Latency with same-cycle dones:
  - 9th pixel accepted at edge E;
  - `start_calculations` high from E;
  - both dones seen during cycle E→E+1;
  - `out_valid` high after edge E+1;
  - minimum 2 cycles from the last pixel to a valid result.
- Throughput: 9 load cycles + 1 calc + ≥1 output = 11 cycles per window minimum.
- Dones arriving in the same cycle or different cycles give identical results, taken in the cycle both are satisfied.
- A done arriving outside CALC is ignored.
- Reset mid-LOAD, CALC or OUTPUT aborts immediately with all outputs at reset values; no partial result is emitted.
- `window_count` wraps 0xFFFF→0x0000 silently.

## Test plan
- Reset: hold `n_rst`=0 mid-LOAD after 4 pixels → all outputs 0, state IDLE; the next 9 pixels form a complete fresh window.
- Flat window: 9×255, gx=0, gy=0, dones same cycle, `out_ready`=1 → `edge_out`=0, `edge_flag`=0, `out_valid` 2 cycles after the 9th pixel, `window_count`=1.
- Saturation: window {50,255,250,100,0,200,100,255,255}, gx=555, gy=300 → `edge_out`=255, `edge_flag`=1; `windowBuffer` matches the input order.
- Staggered dones plus backpressure: `h_done` in CALC cycle 1, `v_done` in cycle 3, gx=100, gy=27, `out_ready` low 5 cycles:
  - `edge_out`=127, `edge_flag`=0, held stable;
  - `pixel_ready`=0 throughout;
  - result accepted on the first `out_ready`.
- Timeout: dones never asserted → `calc_error` pulses exactly at CALC cycle 16, `out_valid` stays 0, `pixel_ready`=1 on the next cycle.
- Stall and wrap: `pixel_valid` gaps during LOAD → same result as a gap-free load; preload `window_count`=0xFFFF via 65535 windows (or force) → next accept gives 0.

Source files
------------

// File: rtl/sobel_window_controller.sv
// Window sequencer around the Sobel gradient blocks: gathers a 3x3 window,
// starts both gradient units, merges gx/gy into a saturated edge result.
module sobel_window_controller #(
  parameter int unsigned THRESHOLD = 128,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [7:0]  windowBuffer [0:8],
  output logic        start_calculations,
  input  logic        h_done,
  input  logic        v_done,
  input  logic [10:0] gx,
  input  logic [10:0] gy,
  output logic [7:0]  edge_out,
  output logic        edge_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        calc_error,
  output logic [15:0] window_count
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUTPUT} state_e;

  localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);
  localparam logic [8:0] THRESHOLD_C = 9'(THRESHOLD);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  win_q [0:8];
  logic [7:0]  win_d [0:8];
  logic        h_seen_q, h_seen_d;
  logic        v_seen_q, v_seen_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  edge_q, edge_d;
  logic        flag_q, flag_d;
  logic        calc_error_q, calc_error_d;
  logic [15:0] window_count_q, window_count_d;

  logic        accept;
  logic        both_done;
  logic [11:0] sum;
  logic [7:0]  sat;

  assign pixel_ready        = (state_q == IDLE) || (state_q == LOAD);
  assign start_calculations = (state_q == CALC);
  assign out_valid          = (state_q == OUTPUT);
  assign windowBuffer       = win_q;
  assign edge_out           = edge_q;
  assign edge_flag          = flag_q;
  assign calc_error         = calc_error_q;
  assign window_count       = window_count_q;

  assign accept    = pixel_valid && pixel_ready;
  // Latched and same-cycle dones both count, so staggered dones finish in the cycle the later one arrives.
  assign both_done = (h_seen_q || h_done) && (v_seen_q || v_done);
  assign sum       = {1'b0, gx} + {1'b0, gy};
  assign sat       = (sum > 12'd255) ? 8'hFF : sum[7:0];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    win_d          = win_q;
    h_seen_d       = h_seen_q;
    v_seen_d       = v_seen_q;
    tcnt_d         = tcnt_q;
    edge_d         = edge_q;
    flag_d         = flag_q;
    calc_error_d   = 1'b0;
    window_count_d = window_count_q;

    if (accept) begin
      win_d[idx_q] = pixel_in;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = idx_q + 4'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (idx_q == 4'd8) begin
            idx_d    = '0;
            h_seen_d = 1'b0;
            v_seen_d = 1'b0;
            tcnt_d   = '0;
            state_d  = CALC;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      CALC: begin
        h_seen_d = h_seen_q || h_done;
        v_seen_d = v_seen_q || v_done;
        if (both_done) begin
          edge_d  = sat;
          flag_d  = ({1'b0, sat} >= THRESHOLD_C);
          state_d = OUTPUT;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_d == TIMEOUT_C) begin
            calc_error_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          window_count_d = window_count_q + 16'd1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      win_q          <= '{default: '0};
      h_seen_q       <= 1'b0;
      v_seen_q       <= 1'b0;
      tcnt_q         <= '0;
      edge_q         <= '0;
      flag_q         <= 1'b0;
      calc_error_q   <= 1'b0;
      window_count_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      win_q          <= win_d;
      h_seen_q       <= h_seen_d;
      v_seen_q       <= v_seen_d;
      tcnt_q         <= tcnt_d;
      edge_q         <= edge_d;
      flag_q         <= flag_d;
      calc_error_q   <= calc_error_d;
      window_count_q <= window_count_d;
    end
  end

endmodule
